wildcard_match_table: RTL and testbench

Programmable, pipelined pattern-match table that generalises a fixed 2-bit `case`/`casez`/`casex` selector decoder. It has DEPTH entries of WIDTH bits, each with a don't-care mask. A run-time mode selects exact, table-side wildcard (casez-like) or both-side wildcard (casex-like) comparison. The block resolves the lowest-index hit, as case-item order does, or falls through to a programmable default. It sits in the datapath between a key producer and a downstream consumer, using valid/ready on both sides.

---
 rtl/wildcard_match_table.sv | 173 +++++++++++++++++
 tb/tb_wildcard_match_table.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wildcard_match_table.sv
`default_nettype none
// ============================================================================
// Module      : wildcard_match_table
// Description : Programmable two-stage match table with exact, entry-mask and
//               entry+key-mask wildcard compare, lowest-index priority and a
//               programmable default result. Valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module wildcard_match_table #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int RES_W = 8,
    parameter int CNT_W = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_en,
    input  logic [WIDTH-1:0] cfg_value,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic [RES_W-1:0] cfg_result,
    input  logic             cfg_def_we,
    input  logic [RES_W-1:0] cfg_def_result,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_key,
    input  logic [WIDTH-1:0] in_kmask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_idx,
    output logic [RES_W-1:0] out_result,
    output logic [CNT_W-1:0] miss_count
);

    // Table storage
    logic             en_q     [DEPTH];
    logic [WIDTH-1:0] value_q  [DEPTH];
    logic [WIDTH-1:0] mask_q   [DEPTH];
    logic [RES_W-1:0] result_q [DEPTH];
    logic [RES_W-1:0] def_q;

    // Stage 1: match vector plus a snapshot of the entry results, so a later
    // cfg write cannot alter a key that has already been captured.
    logic             s1_valid_q;
    logic [DEPTH-1:0] s1_match_q;
    logic [RES_W-1:0] s1_res_q [DEPTH];

    // Stage 2: registered outputs
    logic             out_valid_q;
    logic             out_hit_q;
    logic [IDX_W-1:0] out_idx_q;
    logic [RES_W-1:0] out_result_q;
    logic [CNT_W-1:0] miss_q;

    logic             advance;
    logic [DEPTH-1:0] match_vec;
    logic             hit_d;
    logic [IDX_W-1:0] idx_d;
    logic [RES_W-1:0] res_d;

    // Whole pipeline moves together; it only freezes on an unaccepted result
    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [WIDTH-1:0] care;

        // Care bits per mode; mode 3 behaves as exact match
        always_comb begin
            case (mode)
                2'd1:    care = ~mask_q[i];
                2'd2:    care = ~(mask_q[i] | in_kmask);
                default: care = '1;
            endcase
        end

        assign match_vec[i] = en_q[i] & (((in_key ^ value_q[i]) & care) == '0);
    end

    // Table and default writes; accepted every cycle regardless of stall
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                en_q[i]     <= 1'b0;
                value_q[i]  <= '0;
                mask_q[i]   <= '0;
                result_q[i] <= '0;
            end
            def_q <= '1;
        end else begin
            if (cfg_we) begin
                en_q[cfg_idx]     <= cfg_en;
                value_q[cfg_idx]  <= cfg_value;
                mask_q[cfg_idx]   <= cfg_mask;
                result_q[cfg_idx] <= cfg_result;
            end
            if (cfg_def_we) begin
                def_q <= cfg_def_result;
            end
        end
    end

    // Stage 1 capture at acceptance; bubbles load when no key is offered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_match_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                s1_res_q[i] <= '0;
            end
        end else if (advance) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_match_q <= match_vec;
                for (int i = 0; i < DEPTH; i++) begin
                    s1_res_q[i] <= result_q[i];
                end
            end
        end
    end

    // Fixed-priority encode, lowest index wins; miss falls through to default
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        res_d = def_q;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (s1_match_q[i]) begin
                hit_d = 1'b1;
                idx_d = IDX_W'(i);
                res_d = s1_res_q[i];
            end
        end
    end

    // Stage 2 output register; holds while a result waits for the consumer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_hit_q    <= 1'b0;
            out_idx_q    <= '0;
            out_result_q <= '0;
        end else if (advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_hit_q    <= hit_d;
                out_idx_q    <= idx_d;
                out_result_q <= res_d;
            end
        end
    end

    // Saturating count of delivered misses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if (out_valid_q && out_ready && !out_hit_q && (miss_q != '1)) begin
            miss_q <= miss_q + CNT_W'(1);
        end
    end

    assign out_valid  = out_valid_q;
    assign out_hit    = out_hit_q;
    assign out_idx    = out_idx_q;
    assign out_result = out_result_q;
    assign miss_count = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_wildcard_match_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_wildcard_match_table
// Description : Directed table-driven bench for wildcard_match_table, plus
//               hand sequences for stall, same-cycle cfg, reset and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wildcard_match_table;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we, cfg_en, cfg_def_we;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_value, cfg_mask, cfg_result, cfg_def_result;
    logic [1:0] mode;
    logic       in_valid, out_ready;
    logic [7:0] in_key, in_kmask;

    logic        in_ready, out_valid, out_hit;
    logic [1:0]  out_idx;
    logic [7:0]  out_result;
    logic [15:0] miss_count;

    logic        u4_in_ready, u4_out_valid, u4_out_hit;
    logic [1:0]  u4_out_idx;
    logic [7:0]  u4_out_result;
    logic [3:0]  u4_miss_count;

    int nvec = 0;
    int nmis = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    wildcard_match_table #(.WIDTH(8), .DEPTH(4), .RES_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_value(cfg_value),
        .cfg_mask(cfg_mask), .cfg_result(cfg_result),
        .cfg_def_we(cfg_def_we), .cfg_def_result(cfg_def_result),
        .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_kmask(in_kmask), .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_idx(out_idx), .out_result(out_result),
        .miss_count(miss_count)
    );

    wildcard_match_table #(.WIDTH(8), .DEPTH(4), .RES_W(8), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_value(cfg_value),
        .cfg_mask(cfg_mask), .cfg_result(cfg_result),
        .cfg_def_we(cfg_def_we), .cfg_def_result(cfg_def_result),
        .mode(mode), .in_valid(in_valid), .in_ready(u4_in_ready), .in_key(in_key),
        .in_kmask(in_kmask), .out_valid(u4_out_valid), .out_ready(out_ready),
        .out_hit(u4_out_hit), .out_idx(u4_out_idx), .out_result(u4_out_result),
        .miss_count(u4_miss_count)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic [7:0] key;
        logic [7:0] kmask;
        logic       hit;
        logic [1:0] idx;
        logic [7:0] res;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        exp_miss = 0;
    endtask

    task automatic write_entry(input logic [1:0] idx, input logic en, input logic [7:0] val,
                               input logic [7:0] msk, input logic [7:0] res);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en;
        cfg_value = val; cfg_mask = msk; cfg_result = res;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // One key through an empty pipeline with the consumer always ready
    task automatic run_key(input string name, input logic [1:0] m, input logic [7:0] k,
                           input logic [7:0] km, input logic eh, input logic [1:0] ei,
                           input logic [7:0] er);
        @(negedge clk);
        in_valid = 1'b1; in_key = k; in_kmask = km; mode = m; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({name, " early_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({name, " valid"},  32'(out_valid),  32'd1);
        chk({name, " hit"},    32'(out_hit),    32'(eh));
        chk({name, " idx"},    32'(out_idx),    32'(ei));
        chk({name, " result"}, 32'(out_result), 32'(er));
        if (!eh) exp_miss++;
        @(negedge clk);
        chk({name, " miss_count"}, 32'(miss_count), 32'(exp_miss));
        chk({name, " drained"},    32'(out_valid),  32'd0);
    endtask

    logic [7:0] skeys [3];
    logic       shit  [3];
    logic [1:0] sidx  [3];
    logic [7:0] sres  [3];
    int kidx, nout;

    initial begin
        vt[0] = '{2'd1, 8'h81, 8'h00, 1'b1, 2'd0, 8'h10};
        vt[1] = '{2'd0, 8'h81, 8'h00, 1'b1, 2'd1, 8'h20};
        vt[2] = '{2'd0, 8'h80, 8'h00, 1'b1, 2'd0, 8'h10};
        vt[3] = '{2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 8'hFF};
        vt[4] = '{2'd2, 8'h01, 8'h80, 1'b1, 2'd1, 8'h20};
        vt[5] = '{2'd0, 8'h01, 8'h80, 1'b0, 2'd0, 8'hFF};
        vt[6] = '{2'd3, 8'h01, 8'h80, 1'b0, 2'd0, 8'hFF};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0;
        cfg_value = '0; cfg_mask = '0; cfg_result = '0;
        cfg_def_we = 1'b0; cfg_def_result = '0;
        mode = 2'd0; in_valid = 1'b0; out_ready = 1'b1; in_key = '0; in_kmask = '0;

        do_reset();
        chk("rst out_valid",  32'(out_valid),  32'd0);
        chk("rst in_ready",   32'(in_ready),   32'd1);
        chk("rst out_hit",    32'(out_hit),    32'd0);
        chk("rst out_idx",    32'(out_idx),    32'd0);
        chk("rst out_result", 32'(out_result), 32'd0);
        chk("rst miss_count", 32'(miss_count), 32'd0);

        run_key("empty_table", 2'd0, 8'h00, 8'h00, 1'b0, 2'd0, 8'hFF);

        write_entry(2'd0, 1'b1, 8'h80, 8'h7F, 8'h10);
        write_entry(2'd1, 1'b1, 8'h81, 8'h00, 8'h20);
        for (int i = 0; i < 7; i++) begin
            if (i == 4) write_entry(2'd0, 1'b0, 8'h80, 8'h7F, 8'h10);
            run_key($sformatf("vec%0d", i), vt[i].mode, vt[i].key, vt[i].kmask,
                    vt[i].hit, vt[i].idx, vt[i].res);
        end

        // Streaming with a 3-cycle consumer stall mid-stream
        write_entry(2'd0, 1'b1, 8'h80, 8'h7F, 8'h10);
        skeys[0] = 8'h80; shit[0] = 1'b1; sidx[0] = 2'd0; sres[0] = 8'h10;
        skeys[1] = 8'h81; shit[1] = 1'b1; sidx[1] = 2'd1; sres[1] = 8'h20;
        skeys[2] = 8'h00; shit[2] = 1'b0; sidx[2] = 2'd0; sres[2] = 8'hFF;
        mode = 2'd0; in_kmask = 8'h00;
        kidx = 0; nout = 0;
        for (int cyc = 0; cyc < 40 && nout < 3; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 6);
            if (kidx < 3) begin
                in_valid = 1'b1;
                in_key   = skeys[kidx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) begin
                chk($sformatf("stream%0d hit", nout),    32'(out_hit),    32'(shit[nout]));
                chk($sformatf("stream%0d idx", nout),    32'(out_idx),    32'(sidx[nout]));
                chk($sformatf("stream%0d result", nout), 32'(out_result), 32'(sres[nout]));
                if (!out_ready) begin
                    chk("stream stall in_ready", 32'(in_ready), 32'd0);
                end else begin
                    if (!shit[nout]) exp_miss++;
                    nout++;
                end
            end
            if (in_valid && in_ready) kidx++;
        end
        chk("stream delivered", 32'(nout), 32'd3);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream miss_count", 32'(miss_count), 32'(exp_miss));
        chk("stream drained",    32'(out_valid),  32'd0);

        // Key accepted in the same cycle as a write to entry1.result
        @(negedge clk);
        out_ready = 1'b1; mode = 2'd0; in_kmask = 8'h00;
        in_valid = 1'b1; in_key = 8'h81;
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b1;
        cfg_value = 8'h81; cfg_mask = 8'h00; cfg_result = 8'h33;
        @(negedge clk);
        cfg_we = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("samecfg old valid",  32'(out_valid),  32'd1);
        chk("samecfg old idx",    32'(out_idx),    32'd1);
        chk("samecfg old result", 32'(out_result), 32'h20);
        @(negedge clk);
        chk("samecfg new valid",  32'(out_valid),  32'd1);
        chk("samecfg new result", 32'(out_result), 32'h33);
        @(negedge clk);
        chk("samecfg drained", 32'(out_valid), 32'd0);

        // Reset with both stages occupied
        out_ready = 1'b0; in_valid = 1'b1; in_key = 8'h81;
        @(negedge clk);
        in_key = 8'h80;
        @(negedge clk);
        in_valid = 1'b0;
        chk("full before reset", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_miss = 0;
        chk("midrst out_valid",  32'(out_valid),  32'd0);
        chk("midrst out_result", 32'(out_result), 32'd0);
        chk("midrst in_ready",   32'(in_ready),   32'd1);
        chk("midrst miss_count", 32'(miss_count), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst s1 flushed", 32'(out_valid), 32'd0);
        run_key("cleared e1", 2'd0, 8'h81, 8'h00, 1'b0, 2'd0, 8'hFF);
        run_key("cleared e0", 2'd1, 8'h80, 8'h00, 1'b0, 2'd0, 8'hFF);

        // 20 back-to-back misses: 4-bit counter saturates, 16-bit counts all
        do_reset();
        @(negedge clk);
        out_ready = 1'b1; mode = 2'd0; in_key = 8'h00; in_valid = 1'b1;
        repeat (20) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("sat cnt4",  32'(u4_miss_count), 32'd15);
        chk("sat cnt16", 32'(miss_count),    32'd20);
        repeat (3) @(negedge clk);
        chk("sat cnt4 held", 32'(u4_miss_count), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
